// File: rtl/smem_query_arbiter.sv
// rtl/smem_query_arbiter.sv - round-robin arbiter and in-flight tracker for the read RAM base-query port
// Optional feature macro: QUERY_RANGE_CHK_EN (flags and overrides queries with position >= READ_LEN)
module smem_query_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int READ_NUM_WIDTH = 10,
  parameter int RAM_LAT        = 4,
  parameter int READ_LEN       = 101
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              stall,
  input  logic                              load_done,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*READ_NUM_WIDTH-1:0] req_read_num,
  input  logic [NUM_REQ*7-1:0]              req_position,
  input  logic [NUM_REQ*6-1:0]              req_status,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [READ_NUM_WIDTH-1:0]         ram_query_read_num,
  output logic [6:0]                        ram_query_position,
  output logic [5:0]                        ram_query_status,
  input  logic [7:0]                        ram_query_data,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [7:0]                        rsp_base,
  output logic [READ_NUM_WIDTH-1:0]         rsp_read_num,
  output logic [6:0]                        rsp_position,
  output logic                              rsp_oob
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] READ_LEN_C = 8'(READ_LEN);
  localparam logic [5:0] STATUS_BUBBLE = 6'b00_0000;
  localparam logic [7:0] BASE_N = 8'h04;

  logic [PW-1:0]             rr_ptr;
  logic [NUM_REQ-1:0]        eligible;
  logic                      grant;
  logic [PW-1:0]             winner;
  int                        idx;
  logic [READ_NUM_WIDTH-1:0] win_read_num;
  logic [6:0]                win_position;
  logic [5:0]                win_status;
  logic                      grant_oob;

  // Tracker stages run in lock-step with the RAM's stall-frozen lookup pipeline
  logic [RAM_LAT-1:0]                     trk_valid;
  logic [RAM_LAT-1:0][PW-1:0]             trk_id;
  logic [RAM_LAT-1:0][READ_NUM_WIDTH-1:0] trk_read_num;
  logic [RAM_LAT-1:0][6:0]                trk_position;
  logic [RAM_LAT-1:0]                     trk_oob;

  // Round-robin search for the first eligible requester starting at rr_ptr
  always_comb begin
    eligible = req_valid & {NUM_REQ{load_done & ~stall & reset_n}};
    grant    = 1'b0;
    winner   = '0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant && eligible[idx]) begin
        grant  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  // Winner field selection, one-hot ready and RAM query drive (BUBBLE when idle)
  always_comb begin
    win_read_num = req_read_num[winner*READ_NUM_WIDTH +: READ_NUM_WIDTH];
    win_position = req_position[winner*7 +: 7];
    win_status   = req_status[winner*6 +: 6];
    req_ready    = grant ? (NUM_REQ'(1) << winner) : '0;
    if (grant) begin
      ram_query_read_num = win_read_num;
      ram_query_position = win_position;
      ram_query_status   = win_status;
    end else begin
      ram_query_read_num = '0;
      ram_query_position = '0;
      ram_query_status   = STATUS_BUBBLE;
    end
`ifdef QUERY_RANGE_CHK_EN
    grant_oob = grant && ({1'b0, win_position} >= READ_LEN_C);
`else
    grant_oob = 1'b0;
`endif
  end

  // Pointer update, tracker shift and response capture; everything freezes on stall
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr       <= '0;
      trk_valid    <= '0;
      rsp_valid    <= '0;
      rsp_base     <= 8'hFF;
      rsp_read_num <= '0;
      rsp_position <= '0;
      rsp_oob      <= 1'b0;
    end else if (!stall) begin
      if (grant) begin
        rr_ptr <= (winner == PW'(NUM_REQ - 1)) ? '0 : winner + PW'(1);
      end
      trk_valid[0]    <= grant;
      trk_id[0]       <= winner;
      trk_read_num[0] <= win_read_num;
      trk_position[0] <= win_position;
      trk_oob[0]      <= grant_oob;
      for (int s = 1; s < RAM_LAT; s++) begin
        trk_valid[s]    <= trk_valid[s-1];
        trk_id[s]       <= trk_id[s-1];
        trk_read_num[s] <= trk_read_num[s-1];
        trk_position[s] <= trk_position[s-1];
        trk_oob[s]      <= trk_oob[s-1];
      end
      if (trk_valid[RAM_LAT-1]) begin
        rsp_valid    <= NUM_REQ'(1) << trk_id[RAM_LAT-1];
        rsp_base     <= trk_oob[RAM_LAT-1] ? BASE_N : ram_query_data;
        rsp_read_num <= trk_read_num[RAM_LAT-1];
        rsp_position <= trk_position[RAM_LAT-1];
        rsp_oob      <= trk_oob[RAM_LAT-1];
      end else begin
        rsp_valid <= '0;
      end
    end else begin
      rsp_valid <= '0;
    end
  end

endmodule

// File: tb/tb_smem_query_arbiter.sv
// tb/tb_smem_query_arbiter.sv - scoreboard bench for smem_query_arbiter with a RAM model
module tb_smem_query_arbiter;

  localparam int NR  = 4;
  localparam int W   = 10;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          stall;
  logic          load_done;
  logic [NR-1:0] req_valid;
  logic [NR*W-1:0] req_read_num;
  logic [NR*7-1:0] req_position;
  logic [NR*6-1:0] req_status;
  logic [NR-1:0] req_ready;
  logic [W-1:0]  ram_query_read_num;
  logic [6:0]    ram_query_position;
  logic [5:0]    ram_query_status;
  logic [7:0]    ram_query_data;
  logic [NR-1:0] rsp_valid;
  logic [7:0]    rsp_base;
  logic [W-1:0]  rsp_read_num;
  logic [6:0]    rsp_position;
  logic          rsp_oob;

  smem_query_arbiter #(.NUM_REQ(NR), .READ_NUM_WIDTH(W), .RAM_LAT(LAT), .READ_LEN(101)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .load_done(load_done),
    .req_valid(req_valid), .req_read_num(req_read_num), .req_position(req_position),
    .req_status(req_status), .req_ready(req_ready),
    .ram_query_read_num(ram_query_read_num), .ram_query_position(ram_query_position),
    .ram_query_status(ram_query_status), .ram_query_data(ram_query_data),
    .rsp_valid(rsp_valid), .rsp_base(rsp_base), .rsp_read_num(rsp_read_num),
    .rsp_position(rsp_position), .rsp_oob(rsp_oob)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] base_of(input logic [W-1:0] r, input logic [6:0] p);
    return 8'(32'(r) * 7 + 32'(p) * 13 + 90);
  endfunction

  // RAM model: fixed-latency lookup that freezes with stall
  logic [W-1:0] pipe_r [LAT];
  logic [6:0]   pipe_p [LAT];
  always @(posedge clk) begin
    if (!stall) begin
      pipe_r[0] <= ram_query_read_num;
      pipe_p[0] <= ram_query_position;
      for (int s = 1; s < LAT; s++) begin
        pipe_r[s] <= pipe_r[s-1];
        pipe_p[s] <= pipe_p[s-1];
      end
    end
  end
  assign ram_query_data = base_of(pipe_r[LAT-1], pipe_p[LAT-1]);

  typedef struct {
    int           id;
    logic [7:0]   base;
    logic [W-1:0] rn;
    logic [6:0]   pos;
    logic         oob;
    int           nse;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int m_ptr = 0;
  int nse = 0;
  logic [NR-1:0] last_g = '0;

  logic         cur_v [NR];
  logic [W-1:0] cur_r [NR];
  logic [6:0]   cur_p [NR];
  logic [5:0]   cur_s [NR];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor and reference model: response pop/compare, then grant prediction
  always @(negedge clk) begin
    int w;
    logic [NR-1:0] exp_ready;
    logic [5:0] exp_status;
    exp_t e;
    if (rsp_valid !== '0) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("rsp_onehot", 32'(rsp_valid), 32'(1) << e.id);
        chk("rsp_base", 32'(rsp_base), 32'(e.base));
        chk("rsp_read_num", 32'(rsp_read_num), 32'(e.rn));
        chk("rsp_position", 32'(rsp_position), 32'(e.pos));
        chk("rsp_oob", 32'(rsp_oob), 32'(e.oob));
        chk("rsp_latency", 32'(nse), 32'(e.nse));
      end
    end
    w = -1;
    if (reset_n && load_done && !stall) begin
      for (int k = 0; k < NR; k++) begin
        if (w < 0 && req_valid[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
      end
    end
    exp_ready = (w >= 0) ? NR'(1) << w : '0;
    exp_status = (w >= 0) ? req_status[w*6 +: 6] : 6'd0;
    chk("grant", 32'(req_ready), 32'(exp_ready));
    chk("ram_status", 32'(ram_query_status), 32'(exp_status));
    last_g = req_ready;
    if (w >= 0) begin
      e.id  = w;
      e.rn  = req_read_num[w*W +: W];
      e.pos = req_position[w*7 +: 7];
`ifdef QUERY_RANGE_CHK_EN
      e.oob = (e.pos >= 7'd101);
`else
      e.oob = 1'b0;
`endif
      e.base = e.oob ? 8'h04 : base_of(e.rn, e.pos);
      e.nse = nse + LAT + 1;
      q.push_back(e);
      m_ptr = (w + 1) % NR;
    end
    if (!reset_n) begin
      q.delete();
      m_ptr = 0;
    end else if (!stall) begin
      nse++;
    end
  end

  task automatic drive_bus();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = cur_v[i];
      req_read_num[i*W +: W] = cur_r[i];
      req_position[i*7 +: 7] = cur_p[i];
      req_status[i*6 +: 6] = cur_s[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_fields(input int i);
    cur_r[i] = W'($urandom_range(0, 1023));
    cur_p[i] = 7'($urandom_range(0, 127));
    cur_s[i] = 6'($urandom_range(1, 63));
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) cur_v[i] = 1'b0;
    drive_bus();
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) tick();
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; load_done = 1'b0;
    for (int i = 0; i < NR; i++) begin
      cur_v[i] = 1'b0; new_fields(i);
    end
    drive_bus();
    idle(3);
    chk("reset_base", 32'(rsp_base), 32'hFF);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_read_num", 32'(rsp_read_num), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single query: requester 0, read 5, position 37
    load_done = 1'b1;
    cur_v[0] = 1'b1; cur_r[0] = 10'd5; cur_p[0] = 7'd37; cur_s[0] = 6'h21;
    drive_bus();
    tick();
    clear_all();
    idle(8);

    // All four requesters valid for 8 cycles
    for (int i = 0; i < NR; i++) begin
      cur_v[i] = 1'b1; new_fields(i);
    end
    drive_bus();
    for (int c = 0; c < 8; c++) begin
      tick();
      for (int i = 0; i < NR; i++) if (last_g[i]) new_fields(i);
      drive_bus();
    end
    clear_all();
    idle(8);

    // Single query with a 3-cycle stall starting two cycles after grant
    cur_v[2] = 1'b1; new_fields(2); drive_bus();
    tick();
    cur_v[2] = 1'b0; drive_bus();
    tick();
    stall = 1'b1; cur_v[1] = 1'b1; new_fields(1); drive_bus();
    idle(3);
    stall = 1'b0; clear_all();
    idle(10);

    // load_done low blocks all grants; raising it resumes
    load_done = 1'b0;
    for (int i = 0; i < NR; i++) begin
      cur_v[i] = 1'b1; new_fields(i);
    end
    drive_bus();
    idle(4);
    load_done = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      for (int i = 0; i < NR; i++) if (last_g[i]) cur_v[i] = 1'b0;
      drive_bus();
    end
    clear_all();
    idle(8);

    // Three queries in flight, then a one-cycle reset pulse
    for (int i = 0; i < 3; i++) begin
      cur_v[i] = 1'b1; new_fields(i);
    end
    drive_bus();
    idle(3);
    clear_all();
    reset_n = 1'b0;
    tick();
    chk("midreset_base", 32'(rsp_base), 32'hFF);
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    reset_n = 1'b1;
    idle(8);
    cur_v[3] = 1'b1; cur_v[1] = 1'b1; new_fields(3); new_fields(1); drive_bus();
    tick();
    chk("post_reset_ptr_grant", 32'(last_g), 32'b0010);
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NR; i++) if (last_g[i]) cur_v[i] = 1'b0;
      drive_bus();
      tick();
    end
    clear_all();
    idle(8);

    // Randomized traffic with stalls, load_done drops and occasional resets
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!cur_v[i] || last_g[i]) begin
          cur_v[i] = ($urandom_range(0, 99) < 55);
          new_fields(i);
        end
      end
      stall = ($urandom_range(0, 99) < 15);
      load_done = ($urandom_range(0, 99) < 95);
      reset_n = ($urandom_range(0, 599) != 0);
      drive_bus();
      tick();
    end

    reset_n = 1'b1; stall = 1'b0; load_done = 1'b1;
    clear_all();
    idle(20);
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/smem_query_arbiter.md
Name: smem_query_arbiter

Overview:
- Shares the single base-query port of the read-storage RAM among NUM_REQ pipeline requesters (forward/backward extension queues).
- Round-robin grant of at most one query per non-stalled cycle.
- Tracks each in-flight query through the RAM's fixed 4-stage stall-frozen lookup pipeline and returns the 8-bit base to the originating requester.
- Sits between the SMEM extension queues and the read RAM query interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- READ_NUM_WIDTH, 10, read index width.
- RAM_LAT, 4, non-stalled clock edges from query presentation to valid RAM output.
- READ_LEN, 101, valid query positions are 0..READ_LEN-1.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- stall  in  1  global pipeline stall, same signal that drives the RAM
- load_done  in  1  read RAM fully loaded; no grants while low
- req_valid  in  NUM_REQ  per-requester query valid
- req_read_num  in  NUM_REQ*READ_NUM_WIDTH  packed read indices, requester i at [i*W +: W]
- req_position  in  NUM_REQ*7  packed query positions
- req_status  in  NUM_REQ*6  packed pipeline status
- req_ready  out  NUM_REQ  one-hot grant, combinational
- ram_query_read_num  out  READ_NUM_WIDTH  to RAM query read index
- ram_query_position  out  7  to RAM query position
- ram_query_status  out  6  to RAM status; 6'b00_0000 (BUBBLE) when idle
- ram_query_data  in  8  base returned by RAM
- rsp_valid  out  NUM_REQ  one-hot response pulse, registered
- rsp_base  out  8  returned base
- rsp_read_num  out  READ_NUM_WIDTH  echo of query read index
- rsp_position  out  7  echo of query position
- rsp_oob  out  1  out-of-range flag; 0 when QUERY_RANGE_CHK_EN is off

Behaviour:
- Reset, synchronous, reset_n=0 at a clk edge:
  - rr_ptr=0, tracker valid bits cleared, rsp_valid=0, rsp_base=8'hFF, rsp_read_num=0, rsp_position=0, rsp_oob=0.
  - req_ready=0 while reset_n=0.
  - Reset mid-operation discards all in-flight queries; no response is ever issued for them.
- Grant, combinational:
  - eligible = req_valid & {NUM_REQ{load_done & ~stall & reset_n}}.
  - Winner is the first eligible index searching rr_ptr, rr_ptr+1, … modulo NUM_REQ. req_ready is one-hot to the winner, all-zero if none eligible.
- Requester handshake: a transfer occurs when req_valid[i] & req_ready[i]. A requester holding req_valid while not ready must keep its read_num, position and status stable.
- RAM drive, combinational:
  - On a grant, ram_query_* carry the winner's fields.
  - Otherwise read_num=0, position=0, status=BUBBLE.
- Round-robin pointer: on a grant edge, rr_ptr <= winner+1 (wrap to 0 at NUM_REQ). Unchanged with no grant or during stall.
- Tracker:
  - RAM_LAT-deep shift register of {valid, req_id, read_num, position, oob}.
  - Advances only on edges with stall=0. Stage 1 loads the grant (valid=0 if none). Fully frozen while stall=1, in lock-step with the RAM pipeline.
- Response:
  - On an edge with stall=0 and last-stage valid=1: rsp_valid <= onehot(req_id), rsp_base <= ram_query_data, and echo fields from the last stage.
  - On any other edge rsp_valid <= 0; data fields hold their last value.
  - rsp_valid is high for exactly one cycle per query, never duplicated across stalls.
- Latency: grant in cycle t, no stalls → rsp_valid high in cycle t+RAM_LAT+1 (t+5). Each stall cycle in between adds one cycle.
- Throughput: one query per non-stalled cycle. No outstanding limit. Responses return in grant order.
- load_done falling to 0: new grants stop; in-flight queries still complete.
- Simultaneous grant and last-stage exit on the same edge are independent; both occur.

Optional Feature:
- QUERY_RANGE_CHK_EN:
  - Defined: a granted query with position >= READ_LEN is still tracked, but its response returns rsp_base=8'h04 (N) and rsp_oob=1, ignoring RAM data.
  - Undefined: rsp_oob is tied 0 and RAM data is returned unconditionally.

Test Plan:
- Reset, then load_done=1, req_valid=4'b0001, read_num=5, position=37 at cycle t → req_ready=4'b0001 at t; rsp_valid=4'b0001 at t+5 with rsp_base equal to base 37 of read 5, rsp_read_num=5, rsp_position=37.
- All four requesters valid continuously for 8 cycles, rr_ptr=0 → grants 0,1,2,3,0,1,2,3; responses in the same order, one per cycle, starting 5 cycles after the first grant.
- Single query granted, stall=1 for 3 cycles starting at t+2 → rsp_valid at t+8, exactly one pulse; ram_query_status=BUBBLE and req_ready=0 during the stall.
- load_done=0 with req_valid=4'b1111 → req_ready=0 and no responses. Raise load_done → first grant goes to requester 0.
- Three queries in flight, pulse reset_n=0 for one cycle → no rsp_valid afterwards; rr_ptr=0; rsp_base=8'hFF.
- With QUERY_RANGE_CHK_EN defined, query position=101 → rsp_base=8'h04 and rsp_oob=1 at t+5. With it undefined, rsp_oob=0.
